// File: rtl/ahb_bus_arbiter.sv
// ============================================================================
// ahb_bus_arbiter : two-master AHB-Lite arbiter with burst lock, pipelined
//                   data-phase ownership and a saturating switch counter.
//                   Optional macro ARB_ROUND_ROBIN_EN selects round-robin ties.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ahb_bus_arbiter #(
   parameter int PARK_MASTER = 0,
   parameter int HIGH_PRI    = 1,
   parameter int CNT_W       = 16
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic             m0_HBUSREQ,
   input  logic             m1_HBUSREQ,
   input  logic [31:0]      m0_HADDR,
   input  logic [31:0]      m1_HADDR,
   input  logic [1:0]       m0_HTRANS,
   input  logic [1:0]       m1_HTRANS,
   input  logic             m0_HWRITE,
   input  logic             m1_HWRITE,
   input  logic [2:0]       m0_HSIZE,
   input  logic [2:0]       m1_HSIZE,
   input  logic [31:0]      m0_HWDATA,
   input  logic [31:0]      m1_HWDATA,
   input  logic             HREADY,
   output logic             m0_HGRANT,
   output logic             m1_HGRANT,
   output logic [31:0]      HADDR,
   output logic [1:0]       HTRANS,
   output logic             HWRITE,
   output logic [2:0]       HSIZE,
   output logic [31:0]      HWDATA,
   output logic             addr_owner,
   output logic             data_owner,
   output logic [CNT_W-1:0] switch_count
);

   typedef enum logic [0:0] {
      OWN0 = 1'b0,
      OWN1 = 1'b1
   } state_t;

   localparam logic             c_PARK   = PARK_MASTER[0];
   localparam logic             c_HIPRI  = HIGH_PRI[0];
   localparam logic [1:0]       c_IDLE   = 2'b00;
   localparam logic [1:0]       c_NONSEQ = 2'b10;
   localparam logic [CNT_W-1:0] c_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] c_MAX    = {CNT_W{1'b1}};

   state_t           r_state;
   state_t           w_nextState;
   logic             r_dataOwner;
   logic             r_dataActive;
   logic             r_grant0;
   logic             r_grant1;
   logic [CNT_W-1:0] r_count;
   logic [1:0]       w_ownTrans;
   logic             w_rearb;
   logic             w_winner;
`ifdef ARB_ROUND_ROBIN_EN
   logic             r_lastGrant;
`endif

   assign w_ownTrans = (r_state == OWN1) ? m1_HTRANS : m0_HTRANS;
   // SEQ and BUSY keep the current owner locked to its burst
   assign w_rearb    = HREADY && ((w_ownTrans == c_IDLE) || (w_ownTrans == c_NONSEQ));

   always_comb begin
      w_winner    = c_PARK;
      w_nextState = r_state;
      case ({m1_HBUSREQ, m0_HBUSREQ})
`ifdef ARB_ROUND_ROBIN_EN
         2'b11:   w_winner = ~r_lastGrant;
`else
         2'b11:   w_winner = c_HIPRI;
`endif
         2'b10:   w_winner = 1'b1;
         2'b01:   w_winner = 1'b0;
         default: w_winner = c_PARK;
      endcase
      if (w_rearb) begin
         w_nextState = state_t'(w_winner);
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state <= state_t'(c_PARK);
      end else begin
         r_state <= w_nextState;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_dataOwner  <= c_PARK;
         r_dataActive <= 1'b0;
         r_grant0     <= ~c_PARK;
         r_grant1     <= c_PARK;
         r_count      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         r_lastGrant  <= c_PARK;
`endif
      end else begin
         r_grant0 <= (w_nextState == OWN0);
         r_grant1 <= (w_nextState == OWN1);
         if (HREADY) begin
            r_dataOwner  <= r_state;
            r_dataActive <= w_ownTrans[1];
         end
         if (w_nextState != r_state) begin
            if (r_count != c_MAX) begin
               r_count <= r_count + c_ONE;
            end
`ifdef ARB_ROUND_ROBIN_EN
            r_lastGrant <= w_nextState;
`endif
         end
      end
   end

   assign m0_HGRANT    = r_grant0;
   assign m1_HGRANT    = r_grant1;
   assign addr_owner   = r_state;
   assign data_owner   = r_dataOwner;
   assign switch_count = r_count;

   assign HADDR  = (r_state == OWN1) ? m1_HADDR  : m0_HADDR;
   assign HWRITE = (r_state == OWN1) ? m1_HWRITE : m0_HWRITE;
   assign HSIZE  = (r_state == OWN1) ? m1_HSIZE  : m0_HSIZE;
   assign HTRANS = HRESET ? c_IDLE : w_ownTrans;
   assign HWDATA = r_dataOwner ? m1_HWDATA : m0_HWDATA;

endmodule

`default_nettype wire
